// File: rtl/pig_impact.sv
// pig_impact: turns per-frame bird/pig pixel overlap into a one-shot
// directional impulse for the pig stage, followed by a frame cooldown.
module pig_impact #(
    parameter logic [11:0]        THRESH   = 12'd8,
    parameter logic signed [16:0] PUSH     = 17'sd64,
    parameter logic [3:0]         COOLDOWN = 4'd15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic [1:0]         game_state,
    input  logic               bird,
    input  logic               pig,
    input  logic [3:0]         pig_dir,
    input  logic signed [16:0] bird_vx,
    input  logic signed [16:0] bird_vy,
    output logic signed [16:0] pig_force_x,
    output logic signed [16:0] pig_force_y,
    output logic               hit,
    output logic [7:0]         hit_count
);

    typedef enum logic [1:0] {IDLE, ARMED, COOL} state_t;

    state_t             state_q;
    logic [11:0]        tot_q, lft_q, top_q, ctr_q;
    logic [11:0]        tot_d, lft_d, top_d, ctr_d;
    logic [3:0]         cool_q;
    logic signed [16:0] fx_q, fy_q;
    logic signed [16:0] fx_d, fy_d;
    logic               hit_q;
    logic [7:0]         hit_count_q;
    logic               clr, ov, x_pos, y_pos, full;

    function automatic logic [11:0] sat_inc(input logic [11:0] c,
                                            input logic en);
        return (en && c != 12'hFFF) ? c + 12'd1 : c;
    endfunction

    // 18-bit sum so the full-speed case can exceed 17 bits before clamping
    function automatic logic signed [16:0] impulse(
        input logic signed [16:0] v,
        input logic               pos,
        input logic               fullv
    );
        logic signed [17:0] base, push, sum;
        base = fullv ? {v[16], v} : {v[16], v >>> 1};
        push = {PUSH[16], PUSH};
        sum  = pos ? base + push : base - push;
        if (sum > 18'sd65535)
            sum = 18'sd65535;
        else if (sum < -18'sd65535)
            sum = -18'sd65535;
        return sum[16:0];
    endfunction

    assign clr = rst || (game_state == 2'd0) || vsync;
    assign ov  = bird & pig;

    always_comb begin
        tot_d = '0;
        lft_d = '0;
        top_d = '0;
        ctr_d = '0;
        if (!clr) begin
            tot_d = sat_inc(tot_q, ov);
            lft_d = sat_inc(lft_q, ov & ~pig_dir[1]);
            top_d = sat_inc(top_q, ov & ~pig_dir[0]);
            ctr_d = sat_inc(ctr_q, ov & pig_dir[3] & pig_dir[2]);
        end
    end

    always_ff @(posedge clk) begin
        tot_q <= tot_d;
        lft_q <= lft_d;
        top_q <= top_d;
        ctr_q <= ctr_d;
    end

    assign x_pos = {lft_q, 1'b0} > {1'b0, tot_q};
    assign y_pos = {top_q, 1'b0} > {1'b0, tot_q};
    assign full  = ctr_q >= (tot_q >> 1);
    assign fx_d  = impulse(bird_vx, x_pos, full);
    assign fy_d  = impulse(bird_vy, y_pos, full);

    always_ff @(posedge clk) begin
        hit_q <= 1'b0;
        if (rst) begin
            state_q     <= IDLE;
            cool_q      <= '0;
            fx_q        <= '0;
            fy_q        <= '0;
            hit_count_q <= '0;
        end else if (game_state == 2'd0) begin
            state_q <= IDLE;
            cool_q  <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
        end else if (vsync) begin
            unique case (state_q)
                IDLE: begin
                    if (tot_q >= THRESH) begin
                        state_q     <= ARMED;
                        fx_q        <= fx_d;
                        fy_q        <= fy_d;
                        hit_q       <= 1'b1;
                        hit_count_q <= hit_count_q + 8'd1;
                    end
                end
                ARMED: begin
                    state_q <= COOL;
                    fx_q    <= '0;
                    fy_q    <= '0;
                    cool_q  <= COOLDOWN;
                end
                COOL: begin
                    if (cool_q == 4'd0)
                        state_q <= IDLE;
                    else
                        cool_q <= cool_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pig_force_x = fx_q;
    assign pig_force_y = fy_q;
    assign hit         = hit_q;
    assign hit_count   = hit_count_q;

endmodule
